// File: rtl/register_file_ctrl_pkg.sv
// Shared definitions for the register-file sequencer: FSM states and rf strobe codes.
package rf_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // rf_valid is active-low per timer: [1:0] read timer, [2] write timer
  localparam logic [2:0] RF_VALID_IDLE = 3'b111;
  localparam logic [2:0] RF_VALID_RD   = 3'b100;
  localparam logic [2:0] RF_VALID_WR   = 3'b011;

  // R0 is reserved as constant zero and never written
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/register_file_ctrl_if.sv
// Requester-side bus: flattened per-requester payload, grant and completion response.
interface register_file_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 16
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_a;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_b;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_rdata_a;
  logic [DATA_W-1:0]         rsp_rdata_b;

  // Requester side
  modport master (
    output req, req_we, req_addr_a, req_addr_b, req_wdata,
    input  gnt, rsp_valid, rsp_id, rsp_rdata_a, rsp_rdata_b
  );

  // Controller side
  modport slave (
    input  req, req_we, req_addr_a, req_addr_b, req_wdata,
    output gnt, rsp_valid, rsp_id, rsp_rdata_a, rsp_rdata_b
  );
endinterface

// File: rtl/register_file_ctrl_arb.sv
// Round-robin arbiter: searches from pointer+1, pointer moves to the winner on advance.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0] ptr;
  logic            found;

  // First requester after the pointer wins; gnt stays zero when nobody asks
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
        gnt[(int'(ptr) + i) % NUM_REQ] = 1'b1;
        gnt_id = ID_W'((int'(ptr) + i) % NUM_REQ);
        found  = 1'b1;
      end
    end
  end

  // Pointer only moves on an accepted grant so requester 0 wins first after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ptr <= ID_W'(NUM_REQ - 1);
    else if (advance) ptr <= gnt_id;
  end

endmodule

// File: rtl/register_file_ctrl.sv
// Sequencer sharing the register file between requesters: one op in flight,
// strobes the rf, holds its pins stable over the access delay, returns read data.
module register_file_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 16,
  parameter int RF_LATENCY = 3,
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W = (RF_LATENCY > 1) ? $clog2(RF_LATENCY) : 1
) (
  input  logic                clk,
  input  logic                reset,
  register_file_ctrl_if.slave bus,
  output logic                busy,
  output logic [2:0]          rf_valid,
  output logic [ADDR_W-1:0]   rf_read_addr_1,
  output logic [ADDR_W-1:0]   rf_read_addr_2,
  output logic [ADDR_W-1:0]   rf_write_addr,
  output logic [DATA_W-1:0]   rf_write_data,
  input  logic [DATA_W-1:0]   rf_read_1,
  input  logic [DATA_W-1:0]   rf_read_2
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ID_W-1:0]    op_id;
  logic               op_we;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [DATA_W-1:0]  rsp_rdata_a, rsp_rdata_b;

  logic [NUM_REQ-1:0] elig, arb_gnt;
  logic [ID_W-1:0]    arb_id;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr_a, sel_addr_b;
  logic [DATA_W-1:0]  sel_wdata;

  // Grants only exist in IDLE and never while reset is applied
  assign elig = bus.req & {NUM_REQ{(state == S_IDLE) && !reset}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (elig),
    .advance (|arb_gnt),
    .gnt     (arb_gnt),
    .gnt_id  (arb_id)
  );

  assign sel_we     = bus.req_we[arb_id];
  assign sel_addr_a = bus.req_addr_a[arb_id*ADDR_W +: ADDR_W];
  assign sel_addr_b = bus.req_addr_b[arb_id*ADDR_W +: ADDR_W];
  assign sel_wdata  = bus.req_wdata[arb_id*DATA_W +: DATA_W];

  assign bus.gnt         = arb_gnt;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_id      = rsp_id;
  assign bus.rsp_rdata_a = rsp_rdata_a;
  assign bus.rsp_rdata_b = rsp_rdata_b;
  assign busy            = (state != S_IDLE);

  // Sequencer: accept -> strobe one edge -> count out the rf delay -> respond.
  // rf pins are only rewritten on accept, so the idle write-timer refresh
  // keeps re-committing the last (addr,data) pair harmlessly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      op_id          <= '0;
      op_we          <= 1'b0;
      rf_valid       <= RF_VALID_IDLE;
      rf_read_addr_1 <= '0;
      rf_read_addr_2 <= '0;
      rf_write_addr  <= '0;
      rf_write_data  <= '0;
      rsp_valid      <= 1'b0;
      rsp_id         <= '0;
      rsp_rdata_a    <= '0;
      rsp_rdata_b    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|arb_gnt) begin
            op_id <= arb_id;
            op_we <= sel_we;
            state <= S_ISSUE;
            if (sel_we) begin
              // A write to R0 is acknowledged but never reaches the rf
              if (sel_addr_a != ADDR_W'(REG_ZERO)) begin
                rf_valid      <= RF_VALID_WR;
                rf_write_addr <= sel_addr_a;
                rf_write_data <= sel_wdata;
              end
            end else begin
              rf_valid       <= RF_VALID_RD;
              rf_read_addr_1 <= sel_addr_a;
              rf_read_addr_2 <= sel_addr_b;
            end
          end
        end
        S_ISSUE: begin
          rf_valid <= RF_VALID_IDLE;
          cnt      <= CNT_W'(RF_LATENCY - 1);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= op_id;
            rsp_rdata_a <= op_we ? '0 : rf_read_1;
            rsp_rdata_b <= op_we ? '0 : rf_read_2;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_file_ctrl.sv
// Bench for register_file_ctrl: behavioural 3-edge register file plus a
// spec-level reference (memory array + round-robin pointer).
module tb_register_file_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [2:0]  rf_valid;
  logic [4:0]  rf_read_addr_1, rf_read_addr_2, rf_write_addr;
  logic [15:0] rf_write_data, rf_read_1, rf_read_2;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [15:0] mem [32] = '{default: '0};
  int          ptr = N - 1;

  register_file_ctrl_if #(.NUM_REQ(N), .ADDR_W(5), .DATA_W(16)) bus ();

  register_file_ctrl #(.NUM_REQ(N), .ADDR_W(5), .DATA_W(16), .RF_LATENCY(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .busy           (busy),
    .rf_valid       (rf_valid),
    .rf_read_addr_1 (rf_read_addr_1),
    .rf_read_addr_2 (rf_read_addr_2),
    .rf_write_addr  (rf_write_addr),
    .rf_write_data  (rf_write_data),
    .rf_read_1      (rf_read_1),
    .rf_read_2      (rf_read_2)
  );

  always #5 clk = ~clk;

  // Register file: a sampled low strobe restarts a timer, commit two edges later;
  // timers otherwise free-run with a 3-edge period.
  logic [15:0] rf_mem [32] = '{default: '0};
  logic [1:0]  wt = '0, rt = '0;
  logic [15:0] rf_rd1 = '0, rf_rd2 = '0;
  assign rf_read_1 = rf_rd1;
  assign rf_read_2 = rf_rd2;
  always @(posedge clk) begin
    if (!rf_valid[2]) wt <= 2'd1;
    else if (wt == 2'd2) begin wt <= 2'd0; rf_mem[rf_write_addr] <= rf_write_data; end
    else wt <= wt + 2'd1;
    if (rf_valid[1:0] != 2'b11) rt <= 2'd1;
    else if (rt == 2'd2) begin
      rt <= 2'd0; rf_rd1 <= rf_mem[rf_read_addr_1]; rf_rd2 <= rf_mem[rf_read_addr_2];
    end else rt <= rt + 2'd1;
  end

  typedef struct {
    logic [3:0]  gnt;
    int          wc;
    int          lat;
    logic [1:0]  id;
    logic [15:0] ra, rb;
    logic [2:0]  rfv0, rfv1;
    bit          wstb, rstb, to;
  } op_res_t;

  function automatic int rr_pick(int p, logic [3:0] m);
    for (int k = 1; k <= N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int id, input logic we, input logic [4:0] a, input logic [4:0] b,
                         input logic [15:0] wd);
    bus.req[id]              = 1'b1;
    bus.req_we[id]           = we;
    bus.req_addr_a[id*5 +: 5] = a;
    bus.req_addr_b[id*5 +: 5] = b;
    bus.req_wdata[id*16 +: 16] = wd;
  endtask

  // Called at a negedge with requests driven; returns at the negedge where rsp_valid is seen.
  task automatic wait_op(output op_res_t r);
    r = '{gnt: '0, wc: 0, lat: 0, id: '0, ra: '0, rb: '0, rfv0: '0, rfv1: '0,
          wstb: 1'b0, rstb: 1'b0, to: 1'b0};
    #1;
    while (bus.gnt == '0 && r.wc < 30) begin @(negedge clk); #1; r.wc++; end
    if (bus.gnt == '0) begin r.to = 1'b1; bus.req = '0; return; end
    r.gnt = bus.gnt;
    @(posedge clk);
    do begin
      @(negedge clk); r.lat++;
      if (r.lat == 1) begin bus.req = '0; r.rfv0 = rf_valid; end
      if (r.lat == 2) r.rfv1 = rf_valid;
      if (!rf_valid[2]) r.wstb = 1'b1;
      if (rf_valid[1:0] != 2'b11) r.rstb = 1'b1;
    end while (!bus.rsp_valid && r.lat < 20);
    if (!bus.rsp_valid) r.to = 1'b1;
    r.id = bus.rsp_id; r.ra = bus.rsp_rdata_a; r.rb = bus.rsp_rdata_b;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.req = '0; bus.req_we = '0; bus.req_addr_a = '0; bus.req_addr_b = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (rf_valid !== 3'b111) begin n_fail++; $display("FAIL reset_rf_valid got %b exp 111", rf_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    n_checks++; if ({rf_write_addr, rf_write_data, rf_read_addr_1, rf_read_addr_2} !== '0) begin
      n_fail++; $display("FAIL reset_rf_pins got wa=%0d wd=%h ra1=%0d ra2=%0d exp all 0",
                         rf_write_addr, rf_write_data, rf_read_addr_1, rf_read_addr_2); end
    n_checks++; if ({bus.rsp_id, bus.rsp_rdata_a, bus.rsp_rdata_b} !== '0) begin
      n_fail++; $display("FAIL reset_rsp_fields got id=%0d a=%h b=%h exp 0", bus.rsp_id, bus.rsp_rdata_a, bus.rsp_rdata_b); end
    reset = 1'b0; ptr = N - 1;
  endtask

  task automatic test_write_read();
    op_res_t r;
    set_req(0, 1'b1, 5'd5, 5'd0, 16'hBEEF); wait_op(r);
    mem[5] = 16'hBEEF; ptr = 0;
    n_checks++; if (r.to || r.gnt !== 4'b0001) begin n_fail++; $display("FAIL wr_gnt got %b to=%0d exp 0001", r.gnt, r.to); end
    n_checks++; if (r.rfv0 !== 3'b011) begin n_fail++; $display("FAIL wr_strobe got %b exp 011", r.rfv0); end
    n_checks++; if (r.rfv1 !== 3'b111) begin n_fail++; $display("FAIL wr_strobe_end got %b exp 111", r.rfv1); end
    n_checks++; if (r.lat !== 5 || r.id !== 2'd0) begin n_fail++; $display("FAIL wr_rsp got lat=%0d id=%0d exp lat=5 id=0", r.lat, r.id); end
    n_checks++; if (r.ra !== 16'h0 || r.rb !== 16'h0) begin n_fail++; $display("FAIL wr_rdata got %h/%h exp 0/0", r.ra, r.rb); end
    set_req(0, 1'b0, 5'd5, 5'd0, 16'h0); wait_op(r);
    n_checks++; if (r.rfv0 !== 3'b100) begin n_fail++; $display("FAIL rd_strobe got %b exp 100", r.rfv0); end
    n_checks++; if (r.to || r.lat !== 5) begin n_fail++; $display("FAIL rd_latency got %0d to=%0d exp 5", r.lat, r.to); end
    n_checks++; if (r.ra !== 16'hBEEF || r.rb !== 16'h0) begin n_fail++; $display("FAIL rd_data got %h/%h exp beef/0000", r.ra, r.rb); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] gs [5]; int cyc [5]; int n = 0; int c = 0; int e; int lat = 0;
    reset = 1'b1; @(negedge clk); reset = 1'b0; ptr = N - 1;
    for (int k = 0; k < N; k++) set_req(k, 1'b0, 5'(k + 1), 5'(k + 4), 16'h0);
    while (n < 5 && c < 60) begin
      #1;
      if (bus.gnt != '0) begin gs[n] = bus.gnt; cyc[n] = c; n++; end
      @(negedge clk); c++;
    end
    bus.req = '0;
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL b2b_grants got %0d exp 5", n); end
    for (int i = 0; i < n; i++) begin
      e = rr_pick(ptr, 4'b1111); ptr = e;
      n_checks++; if (gs[i] !== 4'(1 << e)) begin n_fail++; $display("FAIL b2b_order[%0d] got %b exp %b", i, gs[i], 4'(1 << e)); end
      if (i > 0) begin
        n_checks++; if (cyc[i] - cyc[i-1] !== 5) begin n_fail++; $display("FAIL b2b_spacing[%0d] got %0d exp 5", i, cyc[i] - cyc[i-1]); end
      end
    end
    while (!bus.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_rdata_a !== mem[1] || bus.rsp_rdata_b !== mem[4]) begin
      n_fail++; $display("FAIL b2b_last_rsp got v=%b id=%0d a=%h b=%h exp v=1 id=0 a=%h b=%h",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_rdata_a, bus.rsp_rdata_b, mem[1], mem[4]); end
  endtask

  task automatic test_r0();
    op_res_t r;
    set_req(2, 1'b1, 5'd0, 5'd0, 16'h1234); wait_op(r); ptr = 2;
    n_checks++; if (r.to || r.lat !== 5 || r.id !== 2'd2) begin n_fail++; $display("FAIL r0_wr_rsp got lat=%0d id=%0d exp 5/2", r.lat, r.id); end
    n_checks++; if (r.wstb !== 1'b0) begin n_fail++; $display("FAIL r0_no_strobe got strobe=%0d exp 0", r.wstb); end
    set_req(1, 1'b0, 5'd0, 5'd5, 16'h0); wait_op(r); ptr = 1;
    n_checks++; if (r.ra !== 16'h0 || r.rb !== mem[5]) begin n_fail++; $display("FAIL r0_read got %h/%h exp 0000/%h", r.ra, r.rb, mem[5]); end
  endtask

  task automatic test_idle_refresh();
    op_res_t r; logic [4:0] wa; logic [15:0] wd; int changed = 0;
    set_req(3, 1'b1, 5'd7, 5'd0, 16'h00AA); wait_op(r); mem[7] = 16'h00AA; ptr = 3;
    wa = rf_write_addr; wd = rf_write_data;
    n_checks++; if (wa !== 5'd7 || wd !== 16'h00AA) begin n_fail++; $display("FAIL refresh_port got %0d/%h exp 7/00aa", wa, wd); end
    repeat (40) begin @(negedge clk); if (rf_write_addr !== wa || rf_write_data !== wd) changed++; end
    n_checks++; if (changed !== 0) begin n_fail++; $display("FAIL refresh_stable got %0d changes exp 0", changed); end
    set_req(0, 1'b0, 5'd7, 5'd5, 16'h0); wait_op(r); ptr = 0;
    n_checks++; if (r.ra !== 16'h00AA || r.rb !== mem[5]) begin n_fail++; $display("FAIL refresh_read got %h/%h exp 00aa/%h", r.ra, r.rb, mem[5]); end
  endtask

  task automatic test_reset_wait();
    op_res_t r; int spurious = 0;
    set_req(2, 1'b0, 5'd7, 5'd5, 16'h0);
    #1; @(posedge clk); @(negedge clk); bus.req = '0;
    set_req(1, 1'b0, 5'd5, 5'd7, 16'h0);
    @(negedge clk); #2; reset = 1'b1;
    repeat (3) begin @(negedge clk); if (bus.rsp_valid) spurious++; end
    #2; reset = 1'b0; ptr = N - 1;
    wait_op(r); ptr = 1;
    n_checks++; if (spurious !== 0 || r.lat < 5) begin n_fail++; $display("FAIL rst_wait_no_rsp got %0d spurious lat=%0d exp 0", spurious, r.lat); end
    n_checks++; if (r.gnt !== 4'b0010 || r.wc !== 0) begin n_fail++; $display("FAIL rst_wait_gnt got %b after %0d exp 0010 after 0", r.gnt, r.wc); end
    n_checks++; if (r.to || r.id !== 2'd1 || r.ra !== mem[5] || r.rb !== mem[7]) begin
      n_fail++; $display("FAIL rst_wait_rsp got id=%0d %h/%h exp 1 %h/%h", r.id, r.ra, r.rb, mem[5], mem[7]); end
  endtask

  task automatic test_reset_midrun();
    set_req(2, 1'b0, 5'd3, 5'd5, 16'h0);
    #1; @(posedge clk); @(negedge clk); bus.req = '0;
    set_req(1, 1'b0, 5'd3, 5'd3, 16'h0);
    @(posedge clk); #1; reset = 1'b1; #1;
    n_checks++; if (rf_valid !== 3'b111 || bus.gnt !== 4'b0 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset got rfv=%b gnt=%b rsp=%b busy=%b exp 111/0000/0/0", rf_valid, bus.gnt, bus.rsp_valid, busy); end
    @(negedge clk); bus.req = '0; #2; reset = 1'b0; ptr = N - 1;
  endtask

  task automatic test_random();
    op_res_t r; logic [3:0] m; int w; logic we [N]; logic [4:0] a [N], b [N]; logic [15:0] wd [N];
    logic [15:0] ea, eb;
    for (int it = 0; it < 40; it++) begin
      m = 4'($urandom_range(1, 15));
      for (int k = 0; k < N; k++) begin
        we[k] = 1'($urandom_range(0, 1)); a[k] = 5'($urandom_range(0, 7)); b[k] = 5'($urandom_range(0, 7));
        wd[k] = 16'($urandom);
        if (m[k]) set_req(k, we[k], a[k], b[k], wd[k]);
      end
      w = rr_pick(ptr, m);
      wait_op(r);
      n_checks++; if (r.to || r.gnt !== 4'(1 << w)) begin n_fail++; $display("FAIL rand_gnt[%0d] got %b exp %b", it, r.gnt, 4'(1 << w)); end
      ptr = w;
      ea = we[w] ? 16'h0 : mem[a[w]]; eb = we[w] ? 16'h0 : mem[b[w]];
      if (we[w] && a[w] != 5'd0) mem[a[w]] = wd[w];
      n_checks++; if (r.lat !== 5 || r.id !== 2'(w) || r.ra !== ea || r.rb !== eb) begin
        n_fail++; $display("FAIL rand_rsp[%0d] got lat=%0d id=%0d %h/%h exp 5 %0d %h/%h", it, r.lat, r.id, r.ra, r.rb, w, ea, eb); end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_write_read();
    test_back_to_back();
    @(negedge clk);
    test_r0();
    test_idle_refresh();
    test_reset_wait();
    test_reset_midrun();
    @(negedge clk);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
